dmem_arbiter: RTL and testbench

- Sits directly downstream of the load and store functional units. Collects their mem_req plus FU_MEM_PACKET requests and grants one at a time to the single data-memory port.
- Tracks the accepted memory transaction tag and returns Dmem2proc_data to the winner with a one-cycle mem_ack pulse.
- Single outstanding transaction; round-robin fairness between requesters.

---
 rtl/dmem_arbiter_pkg.sv | 39 +++
 rtl/dmem_arbiter_if.sv | 36 +++
 rtl/dmem_arbiter_rr.sv | 33 +++
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 tb/tb_dmem_arbiter.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: bus command/size encodings,
// the FU memory packet, the arbiter FSM states and a small index helper.
package dmem_arbiter_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef struct packed {
        BUS_COMMAND      command;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        MEM_SIZE         size;
    } FU_MEM_PACKET;

    typedef enum logic [1:0] {
        IDLE = 2'h0,
        REQ  = 2'h1,
        WAIT = 2'h2,
        DONE = 2'h3
    } DMEM_ARB_STATE;

    // Next requester index after idx, wrapping at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// FU-side request/ack signals and the single data-memory port, bundled.
// master = the arbiter, slave = the environment (FUs + memory).
interface dmem_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4
) ();
    import dmem_arbiter_pkg::*;

    logic [NUM_REQ-1:0]               mem_req;
    FU_MEM_PACKET [NUM_REQ-1:0]       fu_mem_packet;
    logic [NUM_REQ-1:0]               mem_ack;
    logic [XLEN-1:0]                  Dmem2proc_data_out;

    BUS_COMMAND                       proc2Dmem_command;
    logic [XLEN-1:0]                  proc2Dmem_addr;
    logic [XLEN-1:0]                  proc2Dmem_data;
    MEM_SIZE                          proc2Dmem_size;
    logic [TAG_W-1:0]                 Dmem2proc_response;
    logic [XLEN-1:0]                  Dmem2proc_data;
    logic [TAG_W-1:0]                 Dmem2proc_tag;

    modport master (
        input  mem_req, fu_mem_packet,
        input  Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag,
        output mem_ack, Dmem2proc_data_out,
        output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data, proc2Dmem_size
    );

    modport slave (
        output mem_req, fu_mem_packet,
        output Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag,
        input  mem_ack, Dmem2proc_data_out,
        input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data, proc2Dmem_size
    );

endinterface

// File: rtl/dmem_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker. Searches upward from ptr
// (wrapping) and returns a one-hot grant, its index and an any-grant flag.
// Kept generic so it can be reused for CDB arbitration.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    // First requester at or after ptr, in circular order, wins.
    always_comb begin
        int c;
        c     = 0;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            c = int'(ptr) + i;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (!valid && req[c]) begin
                valid    = 1'b1;
                grant[c] = 1'b1;
                idx      = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: grants the single data-memory port to one of NUM_REQ
// load/store FUs at a time, tracks the load tag and pulses mem_ack to the
// winner. Optional macro DMEM_ARB_FIXED_PRIO_EN: fixed priority (highest
// index wins) instead of round robin; no rr pointer in that build.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4
) (
    input logic            clock,
    input logic            reset,
    dmem_arbiter_if.master bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    DMEM_ARB_STATE      state, state_next;
    FU_MEM_PACKET       pkt;
    logic [NUM_REQ-1:0] win_oh;
    logic [NUM_REQ-1:0] ack, ack_prev;
    logic [TAG_W-1:0]   tag;
    logic [XLEN-1:0]    data_out;
    logic               tag_hit;

    logic [NUM_REQ-1:0] grant_oh;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_vld;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Highest index wins. The cycle right after an ack cannot tell a live
    // request from a stale one, so no grant is made then rather than let a
    // lower index jump ahead of the (possibly still requesting) top index.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        if (ack_prev == '0) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.mem_req[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = IDX_W'(i);
                end
            end
            if (grant_vld) grant_oh[grant_idx] = 1'b1;
        end
    end
`else
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   winner;
    logic [NUM_REQ-1:0] eligible;

    // Requesters acked last cycle may still show a stale mem_req; mask them.
    always_comb eligible = bus.mem_req & ~ack_prev;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (grant_oh),
        .idx   (grant_idx),
        .valid (grant_vld)
    );

    // Round-robin pointer moves past the winner once its transaction ends.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
            winner <= '0;
        end else begin
            if (state == IDLE && grant_vld) winner <= grant_idx;
            if (state == DONE) rr_ptr <= IDX_W'(wrap_inc(int'(winner), NUM_REQ));
        end
    end
`endif

    // A zero latched tag never matches, so stale returns after reset are inert.
    always_comb tag_hit = (bus.Dmem2proc_tag == tag) && (tag != '0);

    // Next-state: grant, retry until accepted, wait for load data, ack.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (grant_vld) state_next = REQ;
            REQ:  if (bus.Dmem2proc_response != '0)
                      state_next = (pkt.command == BUS_LOAD) ? WAIT : DONE;
            WAIT: if (tag_hit) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, latched request, load tag and returned data.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            pkt      <= '0;
            win_oh   <= '0;
            tag      <= '0;
            data_out <= '0;
            ack_prev <= '0;
        end else begin
            state    <= state_next;
            ack_prev <= ack;
            if (state == IDLE && grant_vld) begin
                pkt    <= bus.fu_mem_packet[grant_idx];
                win_oh <= grant_oh;
            end
            if (state == REQ && bus.Dmem2proc_response != '0 && pkt.command == BUS_LOAD)
                tag <= bus.Dmem2proc_response;
            if (state == WAIT && tag_hit) data_out <= bus.Dmem2proc_data;
            if (state == DONE) tag <= '0;
        end
    end

    // Outputs decode from registered state only; command is live only in REQ.
    always_comb begin
        ack                    = (state == DONE) ? win_oh : '0;
        bus.mem_ack            = ack;
        bus.Dmem2proc_data_out = data_out;
        bus.proc2Dmem_command  = (state == REQ) ? pkt.command : BUS_NONE;
        bus.proc2Dmem_addr     = pkt.addr;
        bus.proc2Dmem_data     = pkt.data;
        bus.proc2Dmem_size     = pkt.size;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a per-cycle vector table (load, store, stale-req
// masking, rejection, wrong tag, reset mid-WAIT) plus a contention sequence.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    dmem_arbiter_if #(.NUM_REQ(2), .TAG_W(4)) bus ();

    dmem_arbiter #(.NUM_REQ(2), .TAG_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [1:0] CN = 2'h0, CL = 2'h1, CS = 2'h2;

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [3:0]  resp;
        logic [3:0]  dtag;
        logic [31:0] ddata;
        logic [1:0]  ack;
        logic [1:0]  cmd;
        logic [31:0] dout;
        logic [31:0] addr;
    } vec_t;

    localparam int NV = 32;
    vec_t vecs [NV];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic rst, input logic [1:0] req, input logic [3:0] resp,
                                input logic [3:0] dtag, input logic [31:0] ddata,
                                input logic [1:0] ack, input logic [1:0] cmd,
                                input logic [31:0] dout, input logic [31:0] addr);
        vec_t v;
        v.rst = rst; v.req = req; v.resp = resp; v.dtag = dtag; v.ddata = ddata;
        v.ack = ack; v.cmd = cmd; v.dout = dout; v.addr = addr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        int          n;
        bit          pend;
        logic [1:0]  a;
        int          gi;
        int          exp_g [4];

        // Expectations describe outputs at the start of the cycle; inputs
        // listed alongside are applied afterwards and consumed at the next edge.
        vecs[0]  = mk(0, 2'b01, 0, 0, 0,            2'b00, CN, 32'h0,        32'h0);
        vecs[1]  = mk(0, 2'b01, 3, 0, 0,            2'b00, CL, 32'h0,        32'h100);
        vecs[2]  = mk(0, 2'b01, 0, 0, 0,            2'b00, CN, 32'h0,        32'h100);
        vecs[3]  = mk(0, 2'b01, 0, 0, 0,            2'b00, CN, 32'h0,        32'h100);
        vecs[4]  = mk(0, 2'b01, 0, 0, 0,            2'b00, CN, 32'h0,        32'h100);
        vecs[5]  = mk(0, 2'b01, 0, 0, 0,            2'b00, CN, 32'h0,        32'h100);
        vecs[6]  = mk(0, 2'b01, 0, 3, 32'hDEADBEEF, 2'b00, CN, 32'h0,        32'h100);
        vecs[7]  = mk(0, 2'b01, 0, 0, 0,            2'b01, CN, 32'hDEADBEEF, 32'h100);
        vecs[8]  = mk(0, 2'b01, 0, 0, 0,            2'b00, CN, 32'hDEADBEEF, 32'h100);
        vecs[9]  = mk(0, 2'b10, 0, 0, 0,            2'b00, CN, 32'hDEADBEEF, 32'h100);
        vecs[10] = mk(0, 2'b10, 2, 0, 0,            2'b00, CS, 32'hDEADBEEF, 32'h200);
        vecs[11] = mk(0, 2'b10, 0, 0, 0,            2'b10, CN, 32'hDEADBEEF, 32'h200);
        vecs[12] = mk(0, 2'b10, 0, 0, 0,            2'b00, CN, 32'hDEADBEEF, 32'h200);
        vecs[13] = mk(0, 2'b01, 0, 0, 0,            2'b00, CN, 32'hDEADBEEF, 32'h200);
        vecs[14] = mk(0, 2'b01, 0, 0, 0,            2'b00, CL, 32'hDEADBEEF, 32'h100);
        vecs[15] = mk(0, 2'b01, 0, 0, 0,            2'b00, CL, 32'hDEADBEEF, 32'h100);
        vecs[16] = mk(0, 2'b01, 0, 0, 0,            2'b00, CL, 32'hDEADBEEF, 32'h100);
        vecs[17] = mk(0, 2'b01, 7, 7, 32'h22222222, 2'b00, CL, 32'hDEADBEEF, 32'h100);
        vecs[18] = mk(0, 2'b01, 0, 5, 32'h11111111, 2'b00, CN, 32'hDEADBEEF, 32'h100);
        vecs[19] = mk(0, 2'b01, 0, 7, 32'hCAFEF00D, 2'b00, CN, 32'hDEADBEEF, 32'h100);
        vecs[20] = mk(0, 2'b01, 0, 0, 0,            2'b01, CN, 32'hCAFEF00D, 32'h100);
        vecs[21] = mk(0, 2'b00, 0, 0, 0,            2'b00, CN, 32'hCAFEF00D, 32'h100);
        vecs[22] = mk(0, 2'b01, 0, 0, 0,            2'b00, CN, 32'hCAFEF00D, 32'h100);
        vecs[23] = mk(0, 2'b01, 9, 0, 0,            2'b00, CL, 32'hCAFEF00D, 32'h100);
        vecs[24] = mk(1, 2'b01, 0, 0, 0,            2'b00, CN, 32'hCAFEF00D, 32'h100);
        vecs[25] = mk(0, 2'b00, 0, 9, 32'h99999999, 2'b00, CN, 32'h0,        32'h0);
        vecs[26] = mk(0, 2'b00, 0, 0, 0,            2'b00, CN, 32'h0,        32'h0);
        vecs[27] = mk(0, 2'b01, 0, 0, 0,            2'b00, CN, 32'h0,        32'h0);
        vecs[28] = mk(0, 2'b01, 4, 0, 0,            2'b00, CL, 32'h0,        32'h100);
        vecs[29] = mk(0, 2'b01, 0, 4, 32'h0BADF00D, 2'b00, CN, 32'h0,        32'h100);
        vecs[30] = mk(0, 2'b01, 0, 0, 0,            2'b01, CN, 32'h0BADF00D, 32'h100);
        vecs[31] = mk(0, 2'b00, 0, 0, 0,            2'b00, CN, 32'h0BADF00D, 32'h100);

        reset                  = 1'b1;
        bus.mem_req            = '0;
        bus.Dmem2proc_response = '0;
        bus.Dmem2proc_tag      = '0;
        bus.Dmem2proc_data     = '0;
        bus.fu_mem_packet[0]   = '{command: BUS_LOAD,  addr: 32'h100, data: 32'h0,  size: WORD};
        bus.fu_mem_packet[1]   = '{command: BUS_STORE, addr: 32'h200, data: 32'h55, size: WORD};
        repeat (2) @(posedge clock);

        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            chk($sformatf("v%0d_ack", i),  {30'h0, bus.mem_ack},           {30'h0, vecs[i].ack});
            chk($sformatf("v%0d_cmd", i),  {30'h0, bus.proc2Dmem_command}, {30'h0, vecs[i].cmd});
            chk($sformatf("v%0d_dout", i), bus.Dmem2proc_data_out,         vecs[i].dout);
            chk($sformatf("v%0d_addr", i), bus.proc2Dmem_addr,             vecs[i].addr);
            if (vecs[i].cmd == CS) begin
                chk($sformatf("v%0d_sdata", i), bus.proc2Dmem_data, 32'h55);
                chk($sformatf("v%0d_size", i), {30'h0, bus.proc2Dmem_size}, {30'h0, WORD});
            end
            reset                  = vecs[i].rst;
            bus.mem_req            = vecs[i].req;
            bus.Dmem2proc_response = vecs[i].resp;
            bus.Dmem2proc_tag      = vecs[i].dtag;
            bus.Dmem2proc_data     = vecs[i].ddata;
        end

        // Contention: both FUs request continuously from a fresh reset.
`ifdef DMEM_ARB_FIXED_PRIO_EN
        exp_g = '{1, 1, 1, 1};
`else
        exp_g = '{0, 1, 0, 1};
`endif
        @(negedge clock);
        reset                  = 1'b1;
        bus.mem_req            = '0;
        bus.Dmem2proc_response = '0;
        bus.Dmem2proc_tag      = '0;
        @(negedge clock);
        reset       = 1'b0;
        bus.mem_req = 2'b11;
        n    = 0;
        pend = 1'b0;
        for (int cyc = 0; cyc < 100 && n < 4; cyc++) begin
            @(negedge clock);
            bus.Dmem2proc_response = '0;
            bus.Dmem2proc_tag      = '0;
            bus.Dmem2proc_data     = '0;
            a = bus.mem_ack;
            if (a != 2'b00) begin
                gi = a[1] ? 1 : 0;
                chk($sformatf("cont_onehot%0d", n), {31'h0, $onehot(a)}, 32'h1);
                chk($sformatf("cont_grant%0d", n), gi, exp_g[n]);
                if (gi == 0)
                    chk($sformatf("cont_data%0d", n), bus.Dmem2proc_data_out, 32'hA5A50000 | n);
                n++;
            end
            if (pend) begin
                bus.Dmem2proc_tag  = 4'd1;
                bus.Dmem2proc_data = 32'hA5A50000 | n;
                pend = 1'b0;
            end else if (bus.proc2Dmem_command == BUS_LOAD) begin
                bus.Dmem2proc_response = 4'd1;
                pend = 1'b1;
            end else if (bus.proc2Dmem_command == BUS_STORE) begin
                bus.Dmem2proc_response = 4'd2;
            end
        end
        chk("cont_count", n, 4);
        bus.mem_req = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
